// File: rtl/sw_event_arbiter.sv
// Collects per-channel press/release pulses from the debouncers, holds them as pending,
// and serialises them round-robin onto a single valid/ready event port.
//
// state | meaning
// IDLE  | no event offered; picks the next pending slot starting at ptr
// HOLD  | event offered on ev_*_o, waiting for ev_ready_i
module sw_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] sw_down_i,
    input  logic [N_CH-1:0] sw_up_i,
    input  logic [N_CH-1:0] sw_state_i,
    output logic            ev_valid_o,
    input  logic            ev_ready_i,
    output logic [CH_W-1:0] ev_ch_o,
    output logic            ev_dir_o,
    output logic            ev_state_o,
    output logic [N_CH-1:0] ovf_o,
    input  logic            ovf_clr_i,
    output logic            pend_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [N_CH-1:0] pend_dn;
    logic [N_CH-1:0] pend_up;
    logic [N_CH-1:0] clr_dn;
    logic [N_CH-1:0] clr_up;
    logic [N_CH-1:0] set_ovf;
    logic [CH_W-1:0] ptr;
    logic            accept;
    logic            found;
    logic [CH_W-1:0] grant_ch;
    logic            grant_dir;

    assign accept = (state == HOLD) && ev_ready_i;
    assign pend_o = |{pend_dn, pend_up};

    always_comb begin
        clr_dn = '0;
        clr_up = '0;
        if (accept) begin
            if (ev_dir_o) clr_dn[ev_ch_o] = 1'b1;
            else          clr_up[ev_ch_o] = 1'b1;
        end
    end

    // A pulse onto a slot that stays pending is merged and flagged.
    assign set_ovf = (sw_down_i & pend_dn & ~clr_dn) | (sw_up_i & pend_up & ~clr_up);

    always_comb begin
        int              idx;
        logic [CH_W-1:0] idx_c;
        found     = 1'b0;
        grant_ch  = '0;
        grant_dir = 1'b0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            idx_c = CH_W'(idx);
            if (!found && (pend_dn[idx_c] || pend_up[idx_c])) begin
                found     = 1'b1;
                grant_ch  = idx_c;
                grant_dir = pend_dn[idx_c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pend_dn    <= '0;
            pend_up    <= '0;
            ovf_o      <= '0;
            ptr        <= '0;
            ev_valid_o <= 1'b0;
            ev_ch_o    <= '0;
            ev_dir_o   <= 1'b0;
            ev_state_o <= 1'b0;
        end else begin
            pend_dn <= (pend_dn & ~clr_dn) | sw_down_i;
            pend_up <= (pend_up & ~clr_up) | sw_up_i;
            ovf_o   <= (ovf_clr_i ? '0 : ovf_o) | set_ovf;
            case (state)
                IDLE: begin
                    if (found) begin
                        ev_ch_o    <= grant_ch;
                        ev_dir_o   <= grant_dir;
                        ev_state_o <= sw_state_i[grant_ch];
                        ev_valid_o <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (ev_ready_i) begin
                        ev_valid_o <= 1'b0;
                        ptr        <= (ev_ch_o == CH_W'(N_CH - 1)) ? '0 : ev_ch_o + CH_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_event_arbiter.sv
// Directed bench for sw_event_arbiter: a vector table for reset, single events and
// round robin, followed by hand sequences for backpressure, overflow and collisions.
module tb_sw_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_down;
    logic [3:0] sw_up;
    logic [3:0] sw_state;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_ch;
    logic       ev_dir;
    logic       ev_state;
    logic [3:0] ovf;
    logic       ovf_clr;
    logic       pend;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sw_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_down_i  (sw_down),
        .sw_up_i    (sw_up),
        .sw_state_i (sw_state),
        .ev_valid_o (ev_valid),
        .ev_ready_i (ev_ready),
        .ev_ch_o    (ev_ch),
        .ev_dir_o   (ev_dir),
        .ev_state_o (ev_state),
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr),
        .pend_o     (pend)
    );

    typedef struct {
        logic       rst;
        logic [3:0] dn;
        logic [3:0] up;
        logic [3:0] st;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [1:0] e_ch;
        logic       e_dir;
        logic       e_st;
        logic [3:0] e_ovf;
        logic       e_pend;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic r, logic [3:0] dn, logic [3:0] up, logic [3:0] st,
                                logic rdy, logic clr, logic v, logic [1:0] ch, logic dir,
                                logic est, logic [3:0] eo, logic ep);
        vec_t x;
        x.rst = r;   x.dn = dn;    x.up = up;   x.st = st;    x.rdy = rdy;  x.clr = clr;
        x.e_valid = v; x.e_ch = ch; x.e_dir = dir; x.e_st = est; x.e_ovf = eo; x.e_pend = ep;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] dn, input logic [3:0] up,
                         input logic [3:0] st, input logic rdy, input logic clr);
        rst = r; sw_down = dn; sw_up = up; sw_state = st; ev_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string name, input logic [1:0] ch, input logic dir, input logic st);
        check({name, ".valid"}, int'(ev_valid), 1);
        check({name, ".ch"},    int'(ev_ch), int'(ch));
        check({name, ".dir"},   int'(ev_dir), int'(dir));
        check({name, ".state"}, int'(ev_state), int'(st));
    endtask

    initial begin
        rst = 1'b1; sw_down = '0; sw_up = '0; sw_state = '0; ev_ready = 1'b0; ovf_clr = 1'b0;

        //             rst dn       up       st       rdy clr | v  ch dir st ovf     pend
        tbl[0]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[1]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 4'b0001, 1, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[3]  = mk(0, 4'b0001, 4'b0000, 4'b0001, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 4'b0001, 1, 0,  1, 0, 1, 1, 4'b0000, 1);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 4'b0001, 1, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[6]  = mk(0, 4'b0100, 4'b0000, 4'b0101, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[7]  = mk(0, 4'b0000, 4'b0000, 4'b0101, 1, 0,  1, 2, 1, 1, 4'b0000, 1);
        tbl[8]  = mk(0, 4'b0000, 4'b0000, 4'b0101, 1, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[9]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[10] = mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[11] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  1, 0, 1, 0, 4'b0000, 1);
        tbl[12] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[13] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  1, 1, 1, 0, 4'b0000, 1);
        tbl[14] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[15] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  1, 2, 1, 0, 4'b0000, 1);
        tbl[16] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  1, 3, 1, 0, 4'b0000, 1);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 0);
        tbl[19] = mk(0, 4'b1001, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[20] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  1, 0, 1, 0, 4'b0000, 1);
        tbl[21] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 1);
        tbl[22] = mk(0, 4'b0000, 4'b0000, 4'b1000, 1, 0,  1, 3, 1, 1, 4'b0000, 1);
        tbl[23] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, 4'b0000, 0);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].dn, tbl[i].up, tbl[i].st, tbl[i].rdy, tbl[i].clr);
            check($sformatf("row%0d.valid", i), int'(ev_valid), int'(tbl[i].e_valid));
            check($sformatf("row%0d.pend", i),  int'(pend), int'(tbl[i].e_pend));
            check($sformatf("row%0d.ovf", i),   int'(ovf), int'(tbl[i].e_ovf));
            if (tbl[i].e_valid || tbl[i].rst) begin
                check($sformatf("row%0d.ch", i),    int'(ev_ch), int'(tbl[i].e_ch));
                check($sformatf("row%0d.dir", i),   int'(ev_dir), int'(tbl[i].e_dir));
                check($sformatf("row%0d.state", i), int'(ev_state), int'(tbl[i].e_st));
            end
        end

        // Backpressure: hold ch1 press for 10 clocks while ch3 release arrives
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0010, 4'b0000, 4'b0010, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0010, 0, 0);
        expect_ev("bp.grant", 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 4'b0000, (i == 0) ? 4'b1000 : 4'b0000, 4'b0000, 0, 0);
            expect_ev($sformatf("bp.hold%0d", i), 2'd1, 1'b1, 1'b1);
        end
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("bp.accept.valid", int'(ev_valid), 0);
        check("bp.accept.pend", int'(pend), 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        expect_ev("bp.next", 2'd3, 1'b0, 1'b0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("bp.done.pend", int'(pend), 0);

        // Overflow: second ch1 press merges while the first is still held
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        check("ovf.pre", int'(ovf), 0);
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        check("ovf.set", int'(ovf), 4'b0010);
        expect_ev("ovf.held", 2'd1, 1'b1, 1'b0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("ovf.accept.valid", int'(ev_valid), 0);
        check("ovf.accept.pend", int'(pend), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
            check($sformatf("ovf.nodup%0d", i), int'(ev_valid), 0);
        end
        check("ovf.sticky", int'(ovf), 4'b0010);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        check("ovf.clr", int'(ovf), 0);
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        expect_ev("ovf.held2", 2'd1, 1'b1, 1'b0);
        drive(0, 4'b0010, 4'b0000, 4'b0000, 0, 1);
        check("ovf.set_beats_clr", int'(ovf), 4'b0010);

        // Set/clear collision on ch0: new press at the accept edge survives
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        expect_ev("col.first", 2'd0, 1'b1, 1'b1);
        drive(0, 4'b0001, 4'b0000, 4'b0001, 1, 0);
        check("col.accept.valid", int'(ev_valid), 0);
        check("col.accept.pend", int'(pend), 1);
        check("col.accept.ovf", int'(ovf), 0);
        drive(0, 4'b0000, 4'b0000, 4'b0001, 1, 0);
        expect_ev("col.second", 2'd0, 1'b1, 1'b1);
        drive(0, 4'b0000, 4'b0000, 4'b0001, 1, 0);
        check("col.done.pend", int'(pend), 0);
        check("col.done.ovf", int'(ovf), 0);

        // ch2 with both directions pending: press first, release after pointer wraps
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0100, 4'b0100, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        expect_ev("ord.down", 2'd2, 1'b1, 1'b0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("ord.gap.valid", int'(ev_valid), 0);
        check("ord.gap.pend", int'(pend), 1);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        expect_ev("ord.up", 2'd2, 1'b0, 1'b0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("ord.done.pend", int'(pend), 0);

        // Reset in HOLD drops the offered event
        drive(0, 4'b1000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        check("rsthold.valid_pre", int'(ev_valid), 1);
        drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        drive(0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        check("rsthold.valid", int'(ev_valid), 0);
        check("rsthold.pend", int'(pend), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
